// File: rtl/pcpi_arbiter.sv
// PCPI arbiter: decodes a CPU coprocessor request and forwards it to a MUL, DIV or
// generic extension port. It returns the chosen port's result, or pulses a timeout if none claims it.
module pcpi_arbiter #(
    parameter bit          ENABLE_MUL     = 1'b1,
    parameter bit          ENABLE_DIV     = 1'b1,
    parameter bit          ENABLE_EXT     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        pcpi_timeout,

    output logic [31:0] co_insn,
    output logic [31:0] co_rs1,
    output logic [31:0] co_rs2,

    output logic        mul_valid,
    input  logic        mul_wr,
    input  logic [31:0] mul_rd,
    input  logic        mul_wait,
    input  logic        mul_ready,

    output logic        div_valid,
    input  logic        div_wr,
    input  logic [31:0] div_rd,
    input  logic        div_wait,
    input  logic        div_ready,

    output logic        ext_valid,
    input  logic        ext_wr,
    input  logic [31:0] ext_rd,
    input  logic        ext_wait,
    input  logic        ext_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StDrain} state_e;
    typedef enum logic [1:0] {TgtNone, TgtMul, TgtDiv, TgtExt} target_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    target_e     target_q, target_d;
    target_e     dec_target;
    logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic        is_mdu;

    logic        sel_wait, sel_ready, sel_wr;
    logic [31:0] sel_rd;

    always_comb begin
        is_mdu = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
        if (is_mdu && !pcpi_insn[14] && ENABLE_MUL) begin
            dec_target = TgtMul;
        end else if (is_mdu && pcpi_insn[14] && ENABLE_DIV) begin
            dec_target = TgtDiv;
        end else if (ENABLE_EXT) begin
            dec_target = TgtExt;
        end else begin
            dec_target = TgtNone;
        end
    end

    // Only the latched target is ever listened to; the other ports are ignored.
    always_comb begin
        sel_wait  = 1'b0;
        sel_ready = 1'b0;
        sel_wr    = 1'b0;
        sel_rd    = '0;
        unique case (target_q)
            TgtMul: begin
                sel_wait  = mul_wait;
                sel_ready = mul_ready;
                sel_wr    = mul_wr;
                sel_rd    = mul_rd;
            end
            TgtDiv: begin
                sel_wait  = div_wait;
                sel_ready = div_ready;
                sel_wr    = div_wr;
                sel_rd    = div_rd;
            end
            TgtExt: begin
                sel_wait  = ext_wait;
                sel_ready = ext_ready;
                sel_wr    = ext_wr;
                sel_rd    = ext_rd;
            end
            default: ;
        endcase
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        insn_d    = insn_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pcpi_valid) begin
                    insn_d   = pcpi_insn;
                    rs1_d    = pcpi_rs1;
                    rs2_d    = pcpi_rs2;
                    target_d = dec_target;
                    cnt_d    = '0;
                    wait_d   = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Priority: CPU abort, then completion, then timeout.
                if (!pcpi_valid) begin
                    wait_d  = 1'b0;
                    state_d = StIdle;
                end else if (sel_ready) begin
                    rd_d    = sel_rd;
                    wr_d    = sel_wr;
                    wait_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q | sel_wait;
                    if (!wait_q) begin
                        cnt_d = cnt_inc;
                    end
                    if (!wait_q && !sel_wait && (cnt_inc == TimeoutVal)) begin
                        timeout_d = 1'b1;
                        wr_d      = 1'b0;
                        wait_d    = 1'b0;
                        state_d   = StDrain;
                    end
                end
            end
            StDone: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (!pcpi_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            target_q  <= TgtNone;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            wait_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            insn_q    <= insn_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mul_valid    = (state_q == StRun) && (target_q == TgtMul);
    assign div_valid    = (state_q == StRun) && (target_q == TgtDiv);
    assign ext_valid    = (state_q == StRun) && (target_q == TgtExt);
    assign pcpi_ready   = (state_q == StDone);
    assign pcpi_wait    = wait_q;
    assign pcpi_timeout = timeout_q;
    assign pcpi_rd      = rd_q;
    assign pcpi_wr      = wr_q;
    assign co_insn      = insn_q;
    assign co_rs1       = rs1_q;
    assign co_rs2       = rs2_q;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// Randomized bench for pcpi_arbiter: a transaction-level model predicts each request's
// outcome (ready, timeout or abort) and the cycle it happens on.
module tb_pcpi_arbiter;

    localparam int unsigned ToMain = 16;
    localparam int unsigned ToNx   = 5;
    localparam int TNone = 0, TMul = 1, TDiv = 2, TExt = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pv, use_nx;
    logic [31:0] insn, rs1, rs2;
    logic        mul_wr, div_wr, ext_wr, mul_wait, div_wait, ext_wait;
    logic        mul_ready, div_ready, ext_ready;
    logic [31:0] mul_rd, div_rd, ext_rd;
    logic        pv_m, pv_n;

    logic        o_wr [2], o_wait [2], o_ready [2], o_to [2];
    logic        o_mulv [2], o_divv [2], o_extv [2];
    logic [31:0] o_rd [2], o_insn [2], o_rs1 [2], o_rs2 [2];

    assign pv_m = pv & ~use_nx;
    assign pv_n = pv & use_nx;

    pcpi_arbiter u_dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pv_m), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
        .pcpi_wr(o_wr[0]), .pcpi_rd(o_rd[0]), .pcpi_wait(o_wait[0]),
        .pcpi_ready(o_ready[0]), .pcpi_timeout(o_to[0]),
        .co_insn(o_insn[0]), .co_rs1(o_rs1[0]), .co_rs2(o_rs2[0]),
        .mul_valid(o_mulv[0]), .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait),
        .mul_ready(mul_ready),
        .div_valid(o_divv[0]), .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait),
        .div_ready(div_ready),
        .ext_valid(o_extv[0]), .ext_wr(ext_wr), .ext_rd(ext_rd), .ext_wait(ext_wait),
        .ext_ready(ext_ready)
    );

    pcpi_arbiter #(
        .ENABLE_DIV(1'b0), .ENABLE_EXT(1'b0), .TIMEOUT_CYCLES(ToNx)
    ) u_dut_nx (
        .clk(clk), .reset(reset),
        .pcpi_valid(pv_n), .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
        .pcpi_wr(o_wr[1]), .pcpi_rd(o_rd[1]), .pcpi_wait(o_wait[1]),
        .pcpi_ready(o_ready[1]), .pcpi_timeout(o_to[1]),
        .co_insn(o_insn[1]), .co_rs1(o_rs1[1]), .co_rs2(o_rs2[1]),
        .mul_valid(o_mulv[1]), .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait),
        .mul_ready(mul_ready),
        .div_valid(o_divv[1]), .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait),
        .div_ready(div_ready),
        .ext_valid(o_extv[1]), .ext_wr(ext_wr), .ext_rd(ext_rd), .ext_wait(ext_wait),
        .ext_ready(ext_ready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd [2];
    logic        exp_wr [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int target_of(input logic [31:0] i, input logic nx);
        logic mext;
        mext = (i[6:0] == 7'h33) && (i[31:25] == 7'h01);
        if (mext && !i[14]) return TMul;
        if (mext && i[14] && !nx) return TDiv;
        if (!nx) return TExt;
        return TNone;
    endfunction

    // Selected port follows the plan; every other port produces random noise.
    task automatic drive_ports(input int k, input int tgt, input int r, input int w,
                               input logic [31:0] rdv, input logic wrv);
        logic rdy, wt, wrb;
        logic [31:0] d;
        for (int p = 1; p <= 3; p++) begin
            if (p == tgt) begin
                rdy = (k == r);
                wt  = (w != 0) && (k >= w);
                d   = rdv;
                wrb = wrv;
            end else begin
                rdy = 1'($urandom_range(0, 1));
                wt  = 1'($urandom_range(0, 1));
                d   = $urandom;
                wrb = 1'($urandom_range(0, 1));
            end
            case (p)
                1: begin mul_ready = rdy; mul_wait = wt; mul_rd = d; mul_wr = wrb; end
                2: begin div_ready = rdy; div_wait = wt; div_rd = d; div_wr = wrb; end
                default: begin ext_ready = rdy; ext_wait = wt; ext_rd = d; ext_wr = wrb; end
            endcase
        end
    endtask

    // r: cycle of selected ready (0 never), w: first wait cycle (0 never),
    // ab: cycle CPU drops pcpi_valid (0 never). Cycle k is the k-th cycle after accept.
    task automatic run_txn(input logic [31:0] i_insn, input logic [31:0] a, input logic [31:0] b,
                           input int r_in, input int w_in, input int ab_in,
                           input logic [31:0] rdv, input logic wrv);
        int to, tgt, end_k, kind, r, w, ab, x;
        r   = r_in;
        w   = w_in;
        ab  = ab_in;
        x   = use_nx ? 1 : 0;
        to  = use_nx ? ToNx : ToMain;
        tgt = target_of(i_insn, use_nx);
        if (tgt == TNone) begin
            r = 0;
            w = 0;
        end
        if (r == 0 && w != 0 && w <= to && ab == 0) ab = to + 2;
        end_k = 0;
        kind  = 0;
        if (ab != 0) begin end_k = ab; kind = 2; end
        if (r != 0 && (end_k == 0 || r < end_k)) begin end_k = r; kind = 0; end
        if ((w == 0 || w > to) && (end_k == 0 || to < end_k)) begin end_k = to; kind = 1; end

        insn = i_insn;
        rs1  = a;
        rs2  = b;
        pv   = 1'b1;
        drive_ports(0, tgt, r, w, rdv, wrv);
        for (int s = 0; s <= end_k; s++) begin
            @(posedge clk);
            #1;
            if (s < end_k) begin
                check_eq("run_mul_valid", o_mulv[x], tgt == TMul);
                check_eq("run_div_valid", o_divv[x], tgt == TDiv);
                check_eq("run_ext_valid", o_extv[x], tgt == TExt);
                check_eq("run_wait", o_wait[x], (w != 0) && (w <= s));
                check_eq("run_ready", o_ready[x], 0);
                check_eq("run_timeout", o_to[x], 0);
                check_eq("co_insn", o_insn[x], i_insn);
                check_eq("co_rs1", o_rs1[x], a);
                check_eq("co_rs2", o_rs2[x], b);
                drive_ports(s + 1, tgt, r, w, rdv, wrv);
                pv = !((ab != 0) && (s + 1 >= ab));
            end else begin
                if (kind == 0) begin
                    exp_rd[x] = rdv;
                    exp_wr[x] = wrv;
                end else if (kind == 1) begin
                    exp_wr[x] = 1'b0;
                end
                check_eq("end_ready", o_ready[x], kind == 0);
                check_eq("end_timeout", o_to[x], kind == 1);
                check_eq("end_valids", {o_mulv[x], o_divv[x], o_extv[x]}, 0);
                check_eq("end_wait", o_wait[x], 0);
                if (kind == 0) check_eq("end_rd", o_rd[x], exp_rd[x]);
                check_eq("end_wr", o_wr[x], exp_wr[x]);
            end
        end
        pv = 1'b0;
        drive_ports(0, TNone, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_eq("post_ready", o_ready[x], 0);
        check_eq("post_timeout", o_to[x], 0);
        check_eq("post_valids", {o_mulv[x], o_divv[x], o_extv[x]}, 0);
        check_eq("post_wait", o_wait[x], 0);
        check_eq("post_rd_hold", o_rd[x], exp_rd[x]);
        check_eq("post_wr_hold", o_wr[x], exp_wr[x]);
        @(posedge clk);
        #1;
    endtask

    task automatic random_txn();
        logic [31:0] ri;
        int to, r, w, ab, sel;
        to  = use_nx ? ToNx : ToMain;
        ri  = $urandom;
        sel = $urandom_range(0, 2);
        if (sel != 2) begin
            ri[6:0]   = 7'h33;
            ri[31:25] = 7'h01;
            ri[14]    = (sel == 1);
        end
        r  = ($urandom_range(0, 3) == 0) ? to : $urandom_range(0, to + 2);
        w  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, to + 2);
        ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, to + 2) : 0;
        run_txn(ri, $urandom, $urandom, r, w, ab, $urandom, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        pv     = 1'b0;
        use_nx = 1'b0;
        insn   = '0;
        rs1    = '0;
        rs2    = '0;
        drive_ports(0, TNone, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = '0;
            exp_wr[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_valids", {o_mulv[i], o_divv[i], o_extv[i]}, 0);
            check_eq("rst_flags", {o_ready[i], o_wait[i], o_to[i], o_wr[i]}, 0);
            check_eq("rst_rd", o_rd[i], 0);
            check_eq("rst_co", o_insn[i] | o_rs1[i] | o_rs2[i], 0);
        end
        reset = 1'b0;

        run_txn(32'h02B50533, 32'd6, 32'd7, 5, 2, 0, 32'd42, 1'b1);
        run_txn(32'h02B54533, 32'd20, 32'd4, 3, 0, 0, 32'd5, 1'b1);
        run_txn(32'h02B50533, 32'd1, 32'd2, ToMain, 0, 0, 32'hCAFE_0001, 1'b1);
        run_txn(32'h0000000B, 32'd3, 32'd4, 8, 0, 4, 32'hDEAD_BEEF, 1'b1);
        run_txn(32'h0000000B, 32'd3, 32'd4, 0, 0, 0, 32'h0, 1'b0);

        // Reset in the middle of a waiting MUL transaction.
        insn      = 32'h02B50533;
        rs1       = 32'd3;
        rs2       = 32'd9;
        pv        = 1'b1;
        drive_ports(0, TNone, 0, 0, 0, 0);
        mul_ready = 1'b0;
        mul_wait  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_valid", o_mulv[0], 1);
        check_eq("pre_rst_wait", o_wait[0], 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valids", {o_mulv[0], o_divv[0], o_extv[0]}, 0);
        check_eq("mid_rst_flags", {o_ready[0], o_wait[0], o_to[0], o_wr[0]}, 0);
        check_eq("mid_rst_rd", o_rd[0], 0);
        check_eq("mid_rst_co", o_insn[0] | o_rs1[0] | o_rs2[0], 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = '0;
            exp_wr[i] = 1'b0;
        end
        run_txn(32'h02B50533, 32'd11, 32'd12, 2, 0, 0, 32'd132, 1'b1);

        for (int n = 0; n < 150; n++) random_txn();

        use_nx = 1'b1;
        run_txn(32'h0000000B, 32'd1, 32'd1, 0, 0, 0, 32'h0, 1'b0);
        run_txn(32'h02B54533, 32'd1, 32'd1, 2, 0, 0, 32'h0, 1'b0);
        run_txn(32'h02B50533, 32'd8, 32'd8, ToNx, 0, 0, 32'd64, 1'b1);
        for (int n = 0; n < 60; n++) random_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
